ccff_bitstream_loader: RTL

- Upstream feeder for a configuration chain built from DFF cells: the chain head D, tail Q, and a common clock.
- Accepts configuration words over a valid/ready handshake and serialises each word MSB-first onto the chain head.
- Drives a shift enable for the chain and counts exactly CHAIN_LEN shifted bits, then reports completion.
- Sits between the bitstream source (JTAG/SPI bridge or testbench) and the first configuration flip-flop of the fabric.

---
 rtl/ccff_loader_pkg.sv | 17 +
 rtl/ccff_piso.sv | 46 ++++
 rtl/ccff_bitstream_loader.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_loader_pkg;

  // Loader FSM states; 2-bit encoding is visible on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Width needed to hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ccff_piso.sv
// Parallel-in / serial-out word register feeding the chain head MSB-first.
// A load takes priority over a shift issued in the same cycle.
module ccff_piso #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              CK,
  input  logic              RSTN,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift,
  output logic              msb,
  output logic [CNT_W-1:0]  bits_left
);

  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  wbits_q, wbits_d;

  // Next word contents: reload, shift left by one, or hold.
  always_comb begin
    sreg_d  = sreg_q;
    wbits_d = wbits_q;
    if (load) begin
      sreg_d  = load_data;
      wbits_d = CNT_W'(DATA_W);
    end else if (shift) begin
      sreg_d = {sreg_q[DATA_W-2:0], 1'b0};
      if (wbits_q != '0) wbits_d = wbits_q - CNT_W'(1);
    end
  end

  // Word register and bits-remaining counter.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      sreg_q  <= '0;
      wbits_q <= '0;
    end else begin
      sreg_q  <= sreg_d;
      wbits_q <= wbits_d;
    end
  end

  assign msb       = sreg_q[DATA_W-1];
  assign bits_left = wbits_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Feeds a DFF configuration chain: accepts words, shifts exactly CHAIN_LEN
// bits MSB-first onto the chain head, then reports completion.
//
// Handshake: a word transfers on a CK edge where cfg_valid and cfg_ready are
// both 1. cfg_ready is a registered output and depends only on loader state,
// never on cfg_valid; the source may change cfg_data freely while no
// transfer takes place.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = cnt_width(CHAIN_LEN)
) (
  input  logic              CK,
  input  logic              RSTN,
  input  logic              start,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              err_start,
  input  logic              chain_tail,
  output logic [CNT_W-1:0]  tail_ones,
  output logic [1:0]        dbg_state
);

  localparam int WB_W = cnt_width(DATA_W);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] tail_ones_q, tail_ones_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             shift_en_q, shift_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_start_q, err_start_d;

  logic             hs;
  logic             piso_shift;
  logic             piso_msb;
  logic [WB_W-1:0]  wbits;

  assign hs         = cfg_valid & cfg_ready_q;
  assign piso_shift = (state_q == ST_SHIFT);

  ccff_piso #(
    .DATA_W (DATA_W),
    .CNT_W  (WB_W)
  ) u_piso (
    .CK        (CK),
    .RSTN      (RSTN),
    .load      (hs),
    .load_data (cfg_data),
    .shift     (piso_shift),
    .msb       (piso_msb),
    .bits_left (wbits)
  );

  // FSM, remaining-bit counter, tail readback and registered output values.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    tail_ones_d = tail_ones_q;
    cfg_ready_d = 1'b0;
    shift_en_d  = 1'b0;
    busy_d      = 1'b0;
    done_d      = done_q;
    err_start_d = err_start_q;

    if (start && (state_q == ST_LOAD || state_q == ST_SHIFT)) err_start_d = 1'b1;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          rem_d       = CNT_W'(CHAIN_LEN);
          tail_ones_d = '0;
          err_start_d = 1'b0;
          done_d      = 1'b0;
          state_d     = ST_LOAD;
          cfg_ready_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      ST_LOAD: begin
        busy_d = 1'b1;
        if (hs) begin
          state_d    = ST_SHIFT;
          shift_en_d = 1'b1;
        end else begin
          cfg_ready_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        busy_d = 1'b1;
        rem_d  = rem_q - CNT_W'(1);
        if (chain_tail && tail_ones_q != CNT_W'(CHAIN_LEN))
          tail_ones_d = tail_ones_q + CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          // Last chain bit captured this edge; leftover word bits are dropped.
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (hs) begin
          // Back-to-back word: next cycle shifts its MSB with no bubble.
          shift_en_d = 1'b1;
        end else if (wbits == WB_W'(1)) begin
          state_d     = ST_LOAD;
          cfg_ready_d = 1'b1;
        end else begin
          shift_en_d  = 1'b1;
          cfg_ready_d = (wbits == WB_W'(2)) && (rem_q > CNT_W'(2));
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      tail_ones_q <= '0;
      cfg_ready_q <= 1'b0;
      shift_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      tail_ones_q <= tail_ones_d;
      cfg_ready_q <= cfg_ready_d;
      shift_en_q  <= shift_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_start_q <= err_start_d;
    end
  end

  assign cfg_ready     = cfg_ready_q;
  assign ccff_head     = piso_msb;
  assign ccff_shift_en = shift_en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_start     = err_start_q;
  assign tail_ones     = tail_ones_q;
  assign dbg_state     = state_q;

endmodule
